// File: rtl/ysyx_24100005_mem_arbiter.sv
// ysyx_24100005_mem_arbiter: two-requester (IFU fetch / LSU load-store) arbiter
// onto one shared memory port, one transaction outstanding at a time.
// FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE, with a per-phase timeout that
// completes the transaction with err=1 and rdata=0.
// Optional feature: define YSYX_24100005_ARB_RR_EN to break IDLE ties
// round-robin. Without it, the LSU always wins ties.
module ysyx_24100005_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // fetch request / response
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  // load/store request / response
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  // shared memory port
  output logic        mem_req_valid,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  // Counter value in the last allowed cycle of a REQ/WAIT phase; the phase
  // times out when the counter would reach TIMEOUT.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        owner_q, owner_d;   // 1 = LSU owns the transaction, 0 = IFU
  logic [15:0] cnt_q, cnt_d;

  logic grant_lsu;
  logic in_idle;
  logic accept_lsu;
  logic accept_ifu;
  logic resp_go;

`ifdef YSYX_24100005_ARB_RR_EN
  logic last_lsu_q, last_lsu_d;    // 1 = LSU was granted last

  // Tie goes to whichever requester was not granted last
  always_comb grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);
`else
  // Fixed priority: LSU wins whenever it is valid
  always_comb grant_lsu = lsu_req_valid;
`endif

  // Ready is gated by rst so nothing is offered while reset is held
  assign in_idle       = (state_q == S_IDLE) & ~rst;
  assign lsu_req_ready = in_idle & grant_lsu;
  assign ifu_req_ready = in_idle & ~grant_lsu & ifu_req_valid;
  assign accept_lsu    = lsu_req_valid & lsu_req_ready;
  assign accept_ifu    = ifu_req_valid & ifu_req_ready;

  // Next-state and capture logic for the transaction FSM
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
`ifdef YSYX_24100005_ARB_RR_EN
    last_lsu_d = last_lsu_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_lsu) begin
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          owner_d = 1'b1;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          cnt_d   = 16'h0;
          state_d = S_REQ;
`ifdef YSYX_24100005_ARB_RR_EN
          last_lsu_d = 1'b1;
`endif
        end else if (accept_ifu) begin
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = 32'h0;
          wmask_d = 8'h0;
          owner_d = 1'b0;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          cnt_d   = 16'h0;
          state_d = S_REQ;
`ifdef YSYX_24100005_ARB_RR_EN
          last_lsu_d = 1'b0;
`endif
        end
      end
      S_REQ: begin
        // A handshake in the timeout cycle still counts as normal progress
        if (mem_req_ready) begin
          cnt_d   = 16'h0;
          state_d = S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        // Writes also wait here for their completion beat
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;   // S_RESP: single response cycle
    endcase
  end

  // State and capture registers; synchronous reset abandons any transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      wen_q   <= 1'b0;
      wdata_q <= 32'h0;
      wmask_q <= 8'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 16'h0;
`ifdef YSYX_24100005_ARB_RR_EN
      last_lsu_q <= 1'b0;   // pointer at IFU so the LSU wins the first tie
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`ifdef YSYX_24100005_ARB_RR_EN
      last_lsu_q <= last_lsu_d;
`endif
    end
  end

  // Memory request port is driven from the captured registers, zero when idle
  assign mem_req_valid = (state_q == S_REQ) & ~rst;
  assign mem_addr      = mem_req_valid ? addr_q  : 32'h0;
  assign mem_wen       = mem_req_valid & wen_q;
  assign mem_wdata     = mem_req_valid ? wdata_q : 32'h0;
  assign mem_wmask     = mem_req_valid ? wmask_q : 8'h0;

  // Response goes only to the owner, and only for the single RESP cycle
  assign resp_go        = (state_q == S_RESP) & ~rst;
  assign lsu_resp_valid = resp_go & owner_q;
  assign ifu_resp_valid = resp_go & ~owner_q;
  assign lsu_rdata      = lsu_resp_valid ? rdata_q : 32'h0;
  assign ifu_rdata      = ifu_resp_valid ? rdata_q : 32'h0;
  assign lsu_resp_err   = lsu_resp_valid & err_q;
  assign ifu_resp_err   = ifu_resp_valid & err_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed bench for ysyx_24100005_mem_arbiter (TIMEOUT=8).
// Inputs change 1ns after posedge; outputs are sampled 2ns after posedge.
module tb_ysyx_24100005_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  ysyx_24100005_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_addr(ifu_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  // Reset with both requesters valid: nothing may be offered or driven
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    ifu_req_valid = 1; lsu_req_valid = 1;
    tick();
    tick();
    #1;
    chk("rst_ifu_ready", {31'h0, ifu_req_ready}, 32'h0);
    chk("rst_lsu_ready", {31'h0, lsu_req_ready}, 32'h0);
    chk("rst_outs", {28'h0, mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_wen}, 32'h0);
    ifu_req_valid = 0; lsu_req_valid = 0;
    tick();
    rst = 0;
    #1;
    chk("post_rst_outs", {24'h0, ifu_req_ready, lsu_req_ready, mem_req_valid,
                          ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err, mem_wen}, 32'h0);
    chk("post_rst_addr", mem_addr, 32'h0);
  endtask

  // Minimum-latency IFU read: accept N, mem req N+1, mem resp N+2, ifu resp N+3
  task automatic ifu_read(input logic [31:0] a, input logic [31:0] d);
    ifu_req_valid = 1; ifu_addr = a;
    #1;
    chk("rd_ifu_ready", {31'h0, ifu_req_ready}, 32'h1);
    chk("rd_lsu_ready", {31'h0, lsu_req_ready}, 32'h0);
    tick();
    ifu_req_valid = 0; ifu_addr = 0; mem_req_ready = 1;
    #1;
    chk("rd_mem_valid", {31'h0, mem_req_valid}, 32'h1);
    chk("rd_mem_addr", mem_addr, a);
    chk("rd_mem_wr", {23'h0, mem_wen, mem_wmask}, 32'h0);
    chk("rd_ready_busy", {31'h0, ifu_req_ready}, 32'h0);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = d;
    #1;
    chk("rd_wait_memv", {31'h0, mem_req_valid}, 32'h0);
    chk("rd_wait_addr0", mem_addr, 32'h0);
    chk("rd_wait_resp", {31'h0, ifu_resp_valid}, 32'h0);
    tick();
    mem_resp_valid = 0; mem_rdata = 0;
    #1;
    chk("rd_resp_valid", {30'h0, lsu_resp_valid, ifu_resp_valid}, 32'h1);
    chk("rd_rdata", ifu_rdata, d);
    chk("rd_err", {31'h0, ifu_resp_err}, 32'h0);
    tick();
    #1;
    chk("rd_resp_once", {31'h0, ifu_resp_valid}, 32'h0);
  endtask

  // LSU read that is brought to WAIT and then left there
  task automatic lsu_read_to_wait(input logic [31:0] a);
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = a;
    tick();
    lsu_req_valid = 0; lsu_addr = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rdata = 32'hA5A5_A5A5;
  endtask

  logic [3:0] exp_grant;
  logic       winner;

  initial begin
    idle_inputs();
    rst = 1;
    do_reset();

    // IFU-only read
    ifu_read(32'h8000_0000, 32'h0010_0093);

    // LSU store with mem_req_ready stalled 4 cycles in REQ
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    #1;
    chk("st_lsu_ready", {31'h0, lsu_req_ready}, 32'h1);
    tick();
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
    for (int i = 0; i < 5; i++) begin
      mem_req_ready = (i == 4);
      #1;
      chk("st_mem_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("st_mem_addr", mem_addr, 32'h8000_1000);
      chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_mem_wen_mask", {23'h0, mem_wen, mem_wmask}, 32'h10F);
      tick();
    end
    mem_req_ready = 0;
    #1;
    chk("st_wait_memv", {31'h0, mem_req_valid}, 32'h0);
    chk("st_wait_noresp", {31'h0, lsu_resp_valid}, 32'h0);
    tick();
    mem_resp_valid = 1;
    #1;
    chk("st_wait_noresp2", {31'h0, lsu_resp_valid}, 32'h0);
    tick();
    mem_resp_valid = 0;
    #1;
    chk("st_resp", {30'h0, lsu_resp_valid, ifu_resp_valid}, 32'h2);
    chk("st_err", {31'h0, lsu_resp_err}, 32'h0);
    tick();

    // Timeout in WAIT: RESP exactly 8 cycles after entering WAIT
    lsu_read_to_wait(32'h8000_2000);
    for (int k = 1; k < 8; k++) begin
      tick();
      #1;
      chk("to_early", {31'h0, lsu_resp_valid}, 32'h0);
    end
    tick();
    #1;
    chk("to_valid", {31'h0, lsu_resp_valid}, 32'h1);
    chk("to_err", {31'h0, lsu_resp_err}, 32'h1);
    chk("to_rdata", lsu_rdata, 32'h0);
    tick();

    // Response arriving in the timeout cycle wins over the timeout
    lsu_read_to_wait(32'h8000_3000);
    for (int k = 1; k < 8; k++) begin
      tick();
      #1;
      chk("tie_to_early", {31'h0, lsu_resp_valid}, 32'h0);
    end
    mem_resp_valid = 1; mem_rdata = 32'h0000_0055;
    tick();
    mem_resp_valid = 0; mem_rdata = 0;
    #1;
    chk("tie_to_valid", {31'h0, lsu_resp_valid}, 32'h1);
    chk("tie_to_err", {31'h0, lsu_resp_err}, 32'h0);
    chk("tie_to_rdata", lsu_rdata, 32'h0000_0055);
    tick();

    // Reset while in WAIT, then a stray memory response
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
    tick();
    ifu_req_valid = 0; ifu_addr = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; rst = 1;
    #1;
    chk("mrst_outs", {29'h0, mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 32'h0);
    tick();
    rst = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0BAD;
    #1;
    chk("mrst_noresp0", {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
    tick();
    mem_resp_valid = 0; mem_rdata = 0;
    #1;
    chk("mrst_noresp1", {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
    chk("mrst_memv", {31'h0, mem_req_valid}, 32'h0);
    ifu_read(32'h8000_0004, 32'h1234_5678);

    // Both requesters valid every cycle for 4 transactions, from reset
    do_reset();
`ifdef YSYX_24100005_ARB_RR_EN
    exp_grant = 4'b0101;   // bit i = 1 means LSU wins transaction i
`else
    exp_grant = 4'b1111;
`endif
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      winner = lsu_req_ready;
      chk("tie_grant", {31'h0, winner}, {31'h0, exp_grant[i]});
      chk("tie_one_ready", {31'h0, lsu_req_ready ^ ifu_req_ready}, 32'h1);
      tick();
      mem_req_ready = 1;
      #1;
      chk("tie_addr", mem_addr, winner ? 32'h8000_0200 : 32'h8000_0100);
      tick();
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'(i);
      tick();
      mem_resp_valid = 0;
      #1;
      chk("tie_resp", {30'h0, lsu_resp_valid, ifu_resp_valid}, winner ? 32'h2 : 32'h1);
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
YSYX_24100005_MEM_ARBITER -- requirements
Module: ysyx_24100005_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum cycles spent in REQ or WAIT before error completion, legal range 1..65535.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 ifu_req_valid in 1, ifu_addr in 32; ifu_req_ready out 1  fetch request channel (read only).
REQ-005 ifu_resp_valid out 1, ifu_rdata out 32, ifu_resp_err out 1  fetch response channel.
REQ-006 lsu_req_valid in 1, lsu_addr in 32, lsu_wen in 1, lsu_wdata in 32, lsu_wmask in 8; lsu_req_ready out 1  load/store request channel.
REQ-007 lsu_resp_valid out 1, lsu_rdata out 32, lsu_resp_err out 1  load/store response channel.
REQ-008 mem_req_valid out 1, mem_addr out 32, mem_wen out 1, mem_wdata out 32, mem_wmask out 8; mem_req_ready in 1  shared memory request port.
REQ-009 mem_resp_valid in 1, mem_rdata in 32  shared memory response port.

Function
REQ-010 The block shall implement FSM states IDLE, REQ, WAIT, RESP, with one transaction outstanding at a time.
REQ-011 In IDLE, it shall assert ready combinationally to exactly one requester: the grant winner if both are valid, otherwise the single valid requester; ready shall be 0 in all other states.
REQ-012 A request shall be accepted when valid&ready are both high; addr/wen/wdata/wmask and the owner ID shall be registered, and IDLE shall go to REQ; IFU requests shall be captured with wen=0, wdata=0, wmask=0.
REQ-013 In REQ, mem_req_valid shall be 1 and mem_* shall be driven from the captured registers, held stable until mem_req_ready=1, then REQ shall go to WAIT.
REQ-014 In WAIT, mem_resp_valid=1 shall capture mem_rdata and go to RESP with err=0; writes shall also wait for mem_resp_valid.
REQ-015 In RESP, the owner's resp_valid shall be 1 for exactly one cycle with the captured rdata/err, the other owner's resp_valid shall be 0, and RESP shall go to IDLE.
REQ-016 Minimum latency shall be: accept at cycle N, mem_req_valid at N+1, resp_valid at N+3, with mem_req_ready at N+1 and mem_resp_valid at N+2; the next accept shall be possible at N+4.
REQ-017 An 16-bit timeout counter shall clear on entry to REQ and WAIT and increment each cycle in those states.
REQ-018 On reaching TIMEOUT, the FSM shall go to RESP with err=1 and rdata=0x0000_0000.
REQ-019 If mem_resp_valid (WAIT) or mem_req_ready (REQ) coincides with the counter reaching TIMEOUT, normal progress shall win and err shall be 0.
REQ-020 mem_resp_valid outside WAIT shall be ignored with no state change.
REQ-021 When mem_req_valid=0, mem_* outputs shall be 0.
REQ-022 Default arbitration shall be fixed priority, with LSU winning whenever both requesters are valid in IDLE.

Reset
REQ-023 On rst=1 at a posedge, the block shall go to IDLE and clear the counter, captured registers and err.
REQ-024 During and immediately after reset, all outputs shall be 0.
REQ-025 Reset mid-transaction shall abandon the transaction with no response issued; a later mem_resp_valid shall be ignored.
REQ-026 Reset shall set the round-robin last-grant pointer to IFU, so the LSU wins the first tie.

Configuration
REQ-027 With YSYX_24100005_ARB_RR_EN defined, ties in IDLE shall go to the requester not granted last, and the last-grant pointer shall update only on accept.
REQ-028 Without YSYX_24100005_ARB_RR_EN, REQ-022 fixed LSU priority shall apply and the pointer shall not exist.

Verification
REQ-029 IFU-only read: ifu_addr=0x8000_0000, mem ready at once, mem_rdata=0x0010_0093 one cycle later -> ifu_resp_valid=1 exactly 3 cycles after accept, ifu_rdata=0x0010_0093, err=0.
REQ-030 LSU store: addr=0x8000_1000, wdata=0xDEAD_BEEF, wmask=0x0F -> mem_* match for the whole REQ phase while mem_req_ready is held 0 for 4 cycles; lsu_resp_valid follows mem_resp_valid by 1 cycle.
REQ-031 Both valid every cycle for 4 transactions -> without the macro the grant order is LSU,LSU,LSU,LSU; with the macro it is LSU,IFU,LSU,IFU.
REQ-032 TIMEOUT=8 with mem_resp_valid never asserted -> lsu_resp_valid=1, lsu_resp_err=1, lsu_rdata=0 exactly 8 cycles after entering WAIT.
REQ-033 rst pulsed while in WAIT, then mem_resp_valid asserted -> no resp_valid on either channel; the next IFU request completes normally.
